aes_wddl_out_decoder: RTL and testbench

// - Output end of the WDDL AES datapath: takes dual-rail state (true/false rails) from the add-round-key stage, converts it back to single-rail ciphertext.
// - Tracks WDDL precharge/evaluate waves and counts evaluate phases from ld. Captures the final-round state and offers it on a valid/ready handshake.
// - Sits between the dual-rail state registers and the single-rail host interface.

---
 rtl/aes_wddl_pkg.sv | 28 ++
 rtl/aes_wddl_out_decoder_if.sv | 25 ++
 rtl/aes_wddl_rail_chk.sv | 25 ++
 rtl/aes_wddl_out_decoder.sv | 139 +++++++++++++
 tb/tb_aes_wddl_out_decoder.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/aes_wddl_pkg.sv
// Shared types and constants for the WDDL AES output decoder.
// Byte order follows the cipher state: sa00 in the top byte, sa33 in the bottom byte.
package aes_wddl_pkg;

    localparam int AES_W  = 128;
    localparam int NBYTES = AES_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        EVAL = 2'd2,
        HOLD = 2'd3
    } fsm_e;

    // Rail-pair classification of the whole 128-pair word
    typedef enum logic [1:0] {
        RC_MIXED = 2'd0,
        RC_ZERO  = 2'd1,
        RC_COMP  = 2'd2,
        RC_ILL   = 2'd3
    } rail_cls_e;

    // LSB position of state byte sa<row><col>
    function automatic int sa_lsb(input int row, input int col);
        return AES_W - 8 - 8 * (4 * col + row);
    endfunction

endpackage

// File: rtl/aes_wddl_out_decoder_if.sv
// Host-side bundle of the decoder: dual-rail input, ld strobe and ciphertext handshake.
// master = dual-rail producer / host side, slave = decoder.
interface aes_wddl_out_decoder_if;
    import aes_wddl_pkg::*;

    logic             ld;
    logic [AES_W-1:0] state_t;
    logic [AES_W-1:0] state_f;
    logic [AES_W-1:0] text_out;
    logic             out_vld;
    logic             out_rdy;
    logic             busy;
    logic             err;

    modport master (
        output ld, state_t, state_f, out_rdy,
        input  text_out, out_vld, busy, err
    );

    modport slave (
        input  ld, state_t, state_f, out_rdy,
        output text_out, out_vld, busy, err
    );

endinterface

// File: rtl/aes_wddl_rail_chk.sv
// Combinational classifier over 128 true/false rail pairs: all-zero, complementary, illegal (11) or mixed.
// Zero latency; no handshake.
module aes_wddl_rail_chk
    import aes_wddl_pkg::*;
(
    input  logic [AES_W-1:0] state_t_i,
    input  logic [AES_W-1:0] state_f_i,
    output rail_cls_e        cls_o
);

    logic zero, comp, ill;

    assign zero = ~|(state_t_i | state_f_i);
    assign comp = &(state_t_i ^ state_f_i);
    assign ill  = |(state_t_i & state_f_i);

    // zero, comp and ill are mutually exclusive, so the order only picks the fallback
    always_comb begin
        cls_o = RC_MIXED;
        if (zero)      cls_o = RC_ZERO;
        else if (comp) cls_o = RC_COMP;
        else if (ill)  cls_o = RC_ILL;
    end

endmodule

// File: rtl/aes_wddl_out_decoder.sv
// WDDL output decoder: counts precharge/evaluate waves after ld, captures the NEVAL-th evaluate as ciphertext.
// Result held on out_vld until out_rdy; WDDL_RAIL_CHECK_EN adds illegal-rail and phase-timeout error exits.
module aes_wddl_out_decoder
    import aes_wddl_pkg::*;
#(
    parameter int NEVAL   = 11,
    parameter int TMO_CYC = 16
) (
    input logic                  clk,
    input logic                  rst,
    aes_wddl_out_decoder_if.slave io
);

    localparam int CNT_W = $clog2(NEVAL + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NEVAL);

    if (NEVAL < 1 || TMO_CYC < 1) begin : g_bad_cfg
        $error("aes_wddl_out_decoder: NEVAL and TMO_CYC must be at least 1");
    end

    rail_cls_e        cls;
    fsm_e             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [AES_W-1:0] text_q, text_d;
    logic             vld_q, vld_d;
    logic             busy_q, busy_d;

    aes_wddl_rail_chk u_rail_chk (
        .state_t_i (io.state_t),
        .state_f_i (io.state_f),
        .cls_o     (cls)
    );

    assign cnt_inc = cnt_q + 1'b1;

`ifdef WDDL_RAIL_CHECK_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC);

    logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
    logic             err_q, err_d;
    logic             in_phase;

    assign tmo_inc  = tmo_q + 1'b1;
    assign in_phase = (state_q == PRE) || (state_q == EVAL);
    assign io.err   = err_q;
`else
    assign io.err   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        text_d  = text_q;
        vld_d   = vld_q;
        busy_d  = busy_q;
`ifdef WDDL_RAIL_CHECK_EN
        err_d   = err_q;
        tmo_d   = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (io.ld) begin
                    state_d = PRE;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
`ifdef WDDL_RAIL_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            PRE: begin
                if (cls == RC_ZERO) state_d = EVAL;
            end
            EVAL: begin
                // Partially evaluated or spacer-mixed words are not counted
                if (cls == RC_COMP) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_LAST) begin
                        text_d  = io.state_t;
                        vld_d   = 1'b1;
                        state_d = HOLD;
                    end else begin
                        state_d = PRE;
                    end
                end
            end
            HOLD: begin
                if (vld_q && io.out_rdy) begin
                    vld_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef WDDL_RAIL_CHECK_EN
        if (in_phase) begin
            tmo_d = (state_d == state_q) ? tmo_inc : '0;
            if (cls == RC_ILL || (state_d == state_q && tmo_inc == TMO_LAST)) begin
                err_d   = 1'b1;
                state_d = IDLE;
                busy_d  = 1'b0;
                vld_d   = 1'b0;
                tmo_d   = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            text_q  <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef WDDL_RAIL_CHECK_EN
            err_q   <= 1'b0;
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            text_q  <= text_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
`ifdef WDDL_RAIL_CHECK_EN
            err_q   <= err_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign io.text_out = text_q;
    assign io.out_vld  = vld_q;
    assign io.busy     = busy_q;

endmodule

// File: tb/tb_aes_wddl_out_decoder.sv
// Directed bench for aes_wddl_out_decoder: nominal block, backpressure, partial wave, illegal pair, mid-block reset.
// Optional-feature cases follow WDDL_RAIL_CHECK_EN.
module tb_aes_wddl_out_decoder;
    import aes_wddl_pkg::*;

    localparam logic [127:0] CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CT2 = 128'h00112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    aes_wddl_out_decoder_if bus ();

    aes_wddl_out_decoder #(.NEVAL(11), .TMO_CYC(16)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ld();
        bus.ld = 1'b1;
        step();
        bus.ld = 1'b0;
    endtask

    function automatic logic [127:0] pat(input int k);
        logic [31:0] w;
        w = 32'h0f1e2d3c ^ (32'(k) * 32'h01010101);
        return {w, ~w, w ^ 32'hffff0000, w + 32'd7};
    endfunction

    // One precharge (all rails 0) followed by one complementary evaluate
    task automatic phase(input logic [127:0] v);
        bus.state_t = '0;
        bus.state_f = '0;
        step();
        bus.state_t = v;
        bus.state_f = ~v;
        step();
    endtask

    task automatic handshake();
        bus.out_rdy = 1'b1;
        step();
        bus.out_rdy = 1'b0;
        bus.state_t = '0;
        bus.state_f = '0;
    endtask

    initial begin
        bus.ld      = 1'b0;
        bus.state_t = '0;
        bus.state_f = '0;
        bus.out_rdy = 1'b0;

        // Reset asserted while idle
        repeat (2) step();
        check("rst_text", bus.text_out, '0);
        check("rst_vld",  128'(bus.out_vld), 128'd0);
        check("rst_busy", 128'(bus.busy), 128'd0);
        check("rst_err",  128'(bus.err), 128'd0);
        rst = 1'b0;
        step();

        // Nominal block with backpressure
        do_ld();
        check("nom_busy", 128'(bus.busy), 128'd1);
        for (int k = 1; k <= 10; k++) phase(pat(k));
        check("nom_vld_after10", 128'(bus.out_vld), 128'd0);
        phase(CT);
        check("nom_vld", 128'(bus.out_vld), 128'd1);
        check("nom_text", bus.text_out, CT);
        check("nom_sa00", 128'(bus.text_out[sa_lsb(0, 0) +: 8]), 128'h39);
        check("nom_sa33", 128'(bus.text_out[sa_lsb(3, 3) +: 8]), 128'h32);
        bus.state_t = '0;
        bus.state_f = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_vld", 128'(bus.out_vld), 128'd1);
            check("hold_text", bus.text_out, CT);
        end
        bus.ld = 1'b1;
        step();
        check("hold_ld_vld", 128'(bus.out_vld), 128'd1);
        check("hold_ld_busy", 128'(bus.busy), 128'd1);
        bus.out_rdy = 1'b1;
        step();
        check("acc_vld", 128'(bus.out_vld), 128'd0);
        check("acc_busy_ld_ignored", 128'(bus.busy), 128'd0);
        bus.ld = 1'b0;
        bus.out_rdy = 1'b0;
        step();
        check("idle_busy", 128'(bus.busy), 128'd0);

        // Partial wave in EVAL 3: lower 64 pairs complementary, upper 64 still 00
        do_ld();
        phase(pat(21));
        phase(pat(22));
        bus.state_t = '0;
        bus.state_f = '0;
        step();
        bus.state_t = {64'h0, pat(23)[63:0]};
        bus.state_f = {64'h0, ~pat(23)[63:0]};
        repeat (3) step();
        check("part_busy", 128'(bus.busy), 128'd1);
        bus.state_t = pat(23);
        bus.state_f = ~pat(23);
        step();
        for (int k = 4; k <= 10; k++) phase(pat(20 + k));
        check("part_vld_after10", 128'(bus.out_vld), 128'd0);
        phase(CT2);
        check("part_vld", 128'(bus.out_vld), 128'd1);
        check("part_text", bus.text_out, CT2);
        handshake();

        // Illegal 11 pair on bit 5 during EVAL 4
        do_ld();
        for (int k = 1; k <= 3; k++) phase(pat(40 + k));
        bus.state_t = '0;
        bus.state_f = '0;
        step();
        bus.state_t = pat(44) | 128'h20;
        bus.state_f = ~pat(44) | 128'h20;
        step();
`ifdef WDDL_RAIL_CHECK_EN
        check("ill_err", 128'(bus.err), 128'd1);
        check("ill_busy", 128'(bus.busy), 128'd0);
        check("ill_vld", 128'(bus.out_vld), 128'd0);
        bus.state_t = 128'h1;
        bus.state_f = '0;
        do_ld();
        check("ld_clears_err", 128'(bus.err), 128'd0);
        repeat (15) step();
        check("tmo_before", 128'(bus.err), 128'd0);
        step();
        check("tmo_err", 128'(bus.err), 128'd1);
        check("tmo_busy", 128'(bus.busy), 128'd0);
        bus.state_t = '0;
`else
        step();
        check("ill_err", 128'(bus.err), 128'd0);
        check("ill_busy", 128'(bus.busy), 128'd1);
        check("ill_vld", 128'(bus.out_vld), 128'd0);
        bus.state_t = pat(44);
        bus.state_f = ~pat(44);
        step();
        for (int k = 5; k <= 10; k++) phase(pat(40 + k));
        check("ill_vld_after10", 128'(bus.out_vld), 128'd0);
        phase(CT);
        check("ill_done_vld", 128'(bus.out_vld), 128'd1);
        check("ill_done_text", bus.text_out, CT);
        handshake();
`endif

        // Reset during EVAL 6 discards the partial count
        step();
        do_ld();
        for (int k = 1; k <= 5; k++) phase(pat(60 + k));
        bus.state_t = '0;
        bus.state_f = '0;
        step();
        rst = 1'b1;
        #2;
        check("mid_rst_text", bus.text_out, '0);
        check("mid_rst_vld", 128'(bus.out_vld), 128'd0);
        check("mid_rst_busy", 128'(bus.busy), 128'd0);
        check("mid_rst_err", 128'(bus.err), 128'd0);
        rst = 1'b0;
        step();
        do_ld();
        for (int k = 1; k <= 10; k++) phase(pat(70 + k));
        check("restart_vld_after10", 128'(bus.out_vld), 128'd0);
        phase(CT);
        check("restart_vld", 128'(bus.out_vld), 128'd1);
        check("restart_text", bus.text_out, CT);
        handshake();
        check("restart_busy_end", 128'(bus.busy), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
